regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-port register file for the 32-bit MIPS datapath: NUM_RD async read

---
 rtl/regfile_mp_scoreboard.sv | 106 ++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with per-register pending bits for issue/writeback tracking.
// Reads are combinational; write ports resolve same-address conflicts in favour of the highest index.
module regfile_mp_scoreboard #(
    parameter int NUM_REG  = 32,
    parameter int ADDR_W   = 5,
    parameter int WIDTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*ADDR_W-1:0]  ra,
    output logic [NUM_RD*WIDTH-1:0]   rd,
    output logic [NUM_RD-1:0]         rd_ready,
    input  logic [NUM_WR-1:0]         we,
    input  logic [NUM_WR*ADDR_W-1:0]  wa,
    input  logic [NUM_WR*WIDTH-1:0]   wd,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_addr,
    output logic                      iss_stall,
    output logic [ADDR_W:0]           busy_cnt
);

    localparam bit BYP  = (BYPASS != 0);
    localparam bit ZREG = (ZERO_REG != 0);

    logic [WIDTH-1:0]   r_regs [NUM_REG];
    logic [NUM_REG-1:0] r_pend;
    logic [ADDR_W:0]    r_busy_cnt;

    logic [WIDTH-1:0]   w_wdat [NUM_REG];
    logic [NUM_REG-1:0] w_wclr;
    logic [NUM_REG-1:0] w_pend_nxt;
    logic [ADDR_W:0]    w_cnt_nxt;
    logic               w_iss_stall;
    logic               w_iss_ok;

    // Per-register write decode; later ports overwrite earlier ones so the youngest producer wins.
    always_comb begin
        w_wclr = '0;
        for (int a = 0; a < NUM_REG; a++) begin
            w_wdat[a] = '0;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] && !(ZREG && wa[i*ADDR_W +: ADDR_W] == '0)) begin
                w_wclr[wa[i*ADDR_W +: ADDR_W]] = 1'b1;
                w_wdat[wa[i*ADDR_W +: ADDR_W]] = wd[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_iss_stall = !rst && iss_valid && r_pend[iss_addr] && !(BYP && w_wclr[iss_addr]);
        w_iss_ok    = !rst && iss_valid && !w_iss_stall && !(ZREG && iss_addr == '0);
    end

    // A same-cycle issue re-arms the bit after the write clears it: the issuer is the newer producer.
    always_comb begin
        w_pend_nxt = '0;
        w_cnt_nxt  = '0;
        for (int a = 0; a < NUM_REG; a++) begin
            w_pend_nxt[a] = (w_iss_ok && iss_addr == ADDR_W'(a)) || (r_pend[a] && !w_wclr[a]);
            w_cnt_nxt     = w_cnt_nxt + (ADDR_W+1)'(w_pend_nxt[a]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NUM_REG; a++) begin
                r_regs[a] <= '0;
            end
            r_pend     <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int a = 0; a < NUM_REG; a++) begin
                if (w_wclr[a]) begin
                    r_regs[a] <= w_wdat[a];
                end
            end
            r_pend     <= w_pend_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        rd       = '0;
        rd_ready = '1;
        for (int j = 0; j < NUM_RD; j++) begin
            logic [ADDR_W-1:0] w_addr;
            w_addr = ra[j*ADDR_W +: ADDR_W];
            if (rst || (ZREG && w_addr == '0)) begin
                rd[j*WIDTH +: WIDTH] = '0;
                rd_ready[j]          = 1'b1;
            end else begin
                rd[j*WIDTH +: WIDTH] = (BYP && w_wclr[w_addr]) ? w_wdat[w_addr] : r_regs[w_addr];
                rd_ready[j]          = !r_pend[w_addr] || (BYP && w_wclr[w_addr]);
            end
        end
    end

    assign iss_stall = w_iss_stall;
    assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: a bypassing instance and a read-first instance share stimulus.
module tb_regfile_mp_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        iss_valid;
    logic [4:0]  iss_addr;

    logic [63:0] rd_b,   rd_n;
    logic [1:0]  rdy_b,  rdy_n;
    logic        stl_b,  stl_n;
    logic [5:0]  cnt_b,  cnt_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rd_ready(rdy_b),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .iss_stall(stl_b), .busy_cnt(cnt_b)
    );

    regfile_mp_scoreboard #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rd_ready(rdy_n),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .iss_stall(stl_n), .busy_cnt(cnt_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        we        = 2'b00;
        iss_valid = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; ra = {5'd9, 5'd5}; we = '0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_addr = '0;
        #3;
        check("init_rd",    rd_b,  64'h0);
        check("init_rdy",   rdy_b, 2'b11);
        check("init_cnt",   cnt_b, 6'd0);
        check("init_stall", stl_b, 1'b0);
        tick();
        rst = 1'b0;

        // Build reg5=DEADBEEF with pending{5,9}; issue 5 alongside its own write.
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
        iss_valid = 1'b1; iss_addr = 5'd5;
        settle();
        check("set5_stall", stl_b, 1'b0);
        tick();
        check("set5_cnt", cnt_b, 6'd1);
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        settle();
        check("pre_rst_rd",  rd_b[31:0], 32'hDEADBEEF);
        check("pre_rst_rdy", rdy_b, 2'b00);
        check("pre_rst_cnt", cnt_b, 6'd2);

        // Mid-cycle reset clears everything before the next edge.
        rst = 1'b1;
        settle();
        check("rst_rd",  rd_b, 64'h0);
        check("rst_rdy", rdy_b, 2'b11);
        check("rst_cnt", cnt_b, 6'd0);
        rst = 1'b0;
        tick();
        settle();
        check("post_rst_rd",  rd_b[31:0], 32'h0);
        check("post_rst_rdy", rdy_b, 2'b11);
        check("post_rst_cnt", cnt_b, 6'd0);

        // Zero register.
        ra = {5'd0, 5'd0};
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFFFFFF};
        iss_valid = 1'b1; iss_addr = 5'd0;
        settle();
        check("zero_byp_rd",  rd_b[31:0], 32'h0);
        check("zero_byp_rdy", rdy_b[0], 1'b1);
        tick();
        settle();
        check("zero_rd",  rd_b[31:0], 32'h0);
        check("zero_rdy", rdy_b[0], 1'b1);
        check("zero_cnt", cnt_b, 6'd0);

        // Same-address write priority.
        ra = {5'd7, 5'd7};
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        settle();
        check("prio_byp_rd", rd_b[31:0], 32'h22);
        check("prio_nb_old", rd_n[31:0], 32'h0);
        tick();
        settle();
        check("prio_rd_b", rd_b[31:0], 32'h22);
        check("prio_rd_n", rd_n[63:32], 32'h22);

        // Scoreboard set / stall / clear.
        ra = {5'd8, 5'd8};
        iss_valid = 1'b1; iss_addr = 5'd8;
        settle();
        check("iss8_stall", stl_b, 1'b0);
        tick();
        settle();
        check("iss8_rdy", rdy_b, 2'b00);
        check("iss8_cnt", cnt_b, 6'd1);
        iss_valid = 1'b1; iss_addr = 5'd8;
        settle();
        check("waw_stall_b", stl_b, 1'b1);
        check("waw_stall_n", stl_n, 1'b1);
        tick();
        settle();
        check("waw_cnt", cnt_b, 6'd1);
        we = 2'b01; wa = {5'd0, 5'd8}; wd = {32'h0, 32'h88};
        settle();
        check("wb8_rdy_b", rdy_b, 2'b11);
        check("wb8_rd_b",  rd_b[31:0], 32'h88);
        check("wb8_rdy_n", rdy_n, 2'b00);
        check("wb8_rd_n",  rd_n[31:0], 32'h0);
        tick();
        settle();
        check("wb8_cnt_b",  cnt_b, 6'd0);
        check("wb8_cnt_n",  cnt_n, 6'd0);
        check("wb8_rdy_n2", rdy_n, 2'b11);
        check("wb8_rd_n2",  rd_n[31:0], 32'h88);

        // Simultaneous writeback and re-issue of reg 3.
        ra = {5'd8, 5'd3};
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        settle();
        check("iss3_cnt", cnt_b, 6'd1);
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h33};
        iss_valid = 1'b1; iss_addr = 5'd3;
        settle();
        check("sc3_stall_b", stl_b, 1'b0);
        check("sc3_stall_n", stl_n, 1'b1);
        tick();
        settle();
        check("sc3_cnt_b", cnt_b, 6'd1);
        check("sc3_rdy_b", rdy_b, 2'b10);
        check("sc3_rd_b",  rd_b[31:0], 32'h33);
        check("sc3_cnt_n", cnt_n, 6'd0);
        check("sc3_rdy_n", rdy_n, 2'b11);

        // Read-first behaviour on a pending register.
        ra = {5'd4, 5'd4};
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        we = 2'b10; wa = {5'd4, 5'd0}; wd = {32'h55, 32'h0};
        settle();
        check("rf4_rd_n",  rd_n[31:0], 32'h0);
        check("rf4_rdy_n", rdy_n, 2'b00);
        check("rf4_rd_b",  rd_b[63:32], 32'h55);
        check("rf4_rdy_b", rdy_b, 2'b11);
        tick();
        settle();
        check("rf4_rd_n2",  rd_n[63:32], 32'h55);
        check("rf4_rdy_n2", rdy_n, 2'b11);
        check("rf4_cnt_n",  cnt_n, 6'd0);
        check("rf4_cnt_b",  cnt_b, 6'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
